// File: rtl/weighted_rr_arbiter.sv
// rtl/weighted_rr_arbiter.sv - N-way weighted round-robin arbiter with registered one-hot grant
module weighted_rr_arbiter #(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_inputs,
  input  logic [N*CW-1:0]      weights,
  output logic [N-1:0]         grant_outputs,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  // Arbitration state: current/last holder, burst progress and latched limit.
  logic [IW-1:0] r_h;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_lim;
  logic [N-1:0]  r_grant;
  logic          r_valid;

  logic          w_hold;
  logic          w_found;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_j;
  logic [CW-1:0] w_wt;
  logic [CW-1:0] w_new_lim;

  // Cyclic search starting just after the last holder; the holder itself is checked last.
  // Walking k downward lets the nearest set bit overwrite any farther one.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_j     = '0;
    for (int k = N; k >= 1; k--) begin
      w_j = IW'((int'(r_h) + k) % N);
      if (req_inputs[w_j]) begin
        w_found = 1'b1;
        w_win   = w_j;
      end
    end
  end

  // Burst limit for the winner (zero weight means one cycle) and the keep-the-grant condition.
  always_comb begin
    w_wt      = weights[int'(w_win)*CW +: CW];
    w_new_lim = (w_wt == '0) ? CW'(1) : w_wt;
    w_hold    = r_valid && req_inputs[r_h] && (r_cnt < r_lim);
  end

  // Grant register: hold the burst, hand over to the next requester, or go idle keeping the last holder.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_grant <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_h     <= IW'(N - 1);
      r_cnt   <= '0;
      r_lim   <= CW'(1);
    end else if (w_hold) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (w_found) begin
      r_grant        <= '0;
      r_grant[w_win] <= 1'b1;
      r_valid        <= 1'b1;
      r_h            <= w_win;
      r_idx          <= w_win;
      r_cnt          <= CW'(1);
      r_lim          <= w_new_lim;
    end else begin
      r_grant <= '0;
      r_valid <= 1'b0;
    end
  end

  assign grant_outputs = r_grant;
  assign grant_valid   = r_valid;
  assign grant_idx     = r_idx;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb/tb_weighted_rr_arbiter.sv - scoreboard bench for weighted_rr_arbiter
module tb_weighted_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_inputs;
  logic [15:0] weights;
  logic [3:0]  grant_outputs;
  logic        grant_valid;
  logic [1:0]  grant_idx;

  typedef struct {
    logic [3:0] g;
    logic       v;
    logic [1:0] idx;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass;
  int   n_total;
  int   n_step;

  weighted_rr_arbiter #(.N(4), .CW(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_inputs    (req_inputs),
    .weights       (weights),
    .grant_outputs (grant_outputs),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus and queue the state expected after the next rising edge.
  task automatic step(input string nm, input logic r, input logic [3:0] req,
                      input logic [3:0] eg, input logic ev, input logic [1:0] ei);
    exp_t e;
    @(negedge clk);
    rst        = r;
    req_inputs = req;
    e.g    = eg;
    e.v    = ev;
    e.idx  = ei;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: after each rising edge, pop one expectation and compare all outputs.
  initial begin
    exp_t e;
    n_pass  = 0;
    n_total = 0;
    n_step  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_step++;
        n_total++;
        if (grant_outputs === e.g) n_pass++;
        else $display("FAIL %s step %0d grant: got %b expected %b", e.name, n_step, grant_outputs, e.g);
        n_total++;
        if (grant_valid === e.v) n_pass++;
        else $display("FAIL %s step %0d valid: got %b expected %b", e.name, n_step, grant_valid, e.v);
        n_total++;
        if (grant_idx === e.idx) n_pass++;
        else $display("FAIL %s step %0d idx: got %0d expected %0d", e.name, n_step, grant_idx, e.idx);
      end
    end
  end

  initial begin
    rst        = 1'b0;
    req_inputs = 4'b0000;
    weights    = 16'h1111;

    // 1: reset dominates all-requesting inputs, then first grant goes to requester 0
    step("reset",      1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0);
    step("reset",      1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0);
    step("reset_rel",  1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);

    // 2: sole requester re-granted every cycle
    step("sole_rst",   1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++)
      step("sole",     1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0);

    // 3: equal weights rotate every cycle
    step("eq_rst",     1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0);
    step("eq",         1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);
    step("eq",         1'b1, 4'b1111, 4'b0010, 1'b1, 2'd1);
    step("eq",         1'b1, 4'b1111, 4'b0100, 1'b1, 2'd2);
    step("eq",         1'b1, 4'b1111, 4'b1000, 1'b1, 2'd3);
    step("eq",         1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);

    // 4: weights w3=0 w2=2 w1=1 w0=3
    weights = {4'd0, 4'd2, 4'd1, 4'd3};
    step("wt_rst",     1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0);
    step("wt",         1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);
    step("wt",         1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);
    step("wt",         1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);
    step("wt",         1'b1, 4'b1111, 4'b0010, 1'b1, 2'd1);
    step("wt",         1'b1, 4'b1111, 4'b0100, 1'b1, 2'd2);
    step("wt",         1'b1, 4'b1111, 4'b0100, 1'b1, 2'd2);
    step("wt",         1'b1, 4'b1111, 4'b1000, 1'b1, 2'd3);
    step("wt",         1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);
    step("wt",         1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);
    step("wt",         1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);
    step("wt",         1'b1, 4'b1111, 4'b0010, 1'b1, 2'd1);

    // 5: drop mid-burst, idle keeps last holder, resume after it
    weights = {4'd1, 4'd1, 4'd1, 4'd3};
    step("drop_rst",   1'b0, 4'b0101, 4'b0000, 1'b0, 2'd0);
    step("drop",       1'b1, 4'b0101, 4'b0001, 1'b1, 2'd0);
    step("drop",       1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2);
    step("idle",       1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2);
    step("idle",       1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2);
    step("resume",     1'b1, 4'b0101, 4'b0001, 1'b1, 2'd0);
    step("resume",     1'b1, 4'b0101, 4'b0001, 1'b1, 2'd0);
    step("resume",     1'b1, 4'b0101, 4'b0001, 1'b1, 2'd0);
    step("resume",     1'b1, 4'b0101, 4'b0100, 1'b1, 2'd2);

    // 6: reset mid-burst, then weight change during a burst
    weights = {4'd1, 4'd1, 4'd1, 4'd5};
    step("mid_rst0",   1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0);
    step("burst",      1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);
    step("burst",      1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);
    step("mid_rst",    1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0);
    step("fresh",      1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);
    step("fresh",      1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);
    weights = {4'd1, 4'd1, 4'd1, 4'd1};
    step("fresh",      1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);
    step("fresh",      1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);
    step("fresh",      1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);
    step("rot",        1'b1, 4'b1111, 4'b0010, 1'b1, 2'd1);
    step("rot",        1'b1, 4'b1111, 4'b0100, 1'b1, 2'd2);
    step("rot",        1'b1, 4'b1111, 4'b1000, 1'b1, 2'd3);
    step("new_wt",     1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0);
    step("new_wt",     1'b1, 4'b1111, 4'b0010, 1'b1, 2'd1);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/weighted_rr_arbiter.md
# weighted_rr_arbiter

- Parametrised, weighted successor to the fixed 3-input cyclic round-robin arbiter.
- Grants one of `N` requesters at a time, with a registered one-hot grant.
- Each requester may hold the grant for up to a programmable number of consecutive cycles (its weight) before rotation.
- Sits between shared-resource clients and the resource; the resource side consumes `grant_outputs`/`grant_idx` directly.

## Interface

Parameters:
- `N`, default 4: number of requesters, at least 2.
- `CW`, default 4: width of each per-requester weight field.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `req_inputs`, input, `N`: request vector; bit i is requester i.
- `weights`, input, `N*CW`: field `[i*CW +: CW]` is the burst length for requester i. A value of 0 is treated as 1.
- `grant_outputs`, output, `N`: registered one-hot grant, or all-zero when idle.
- `grant_valid`, output, 1: high when `grant_outputs` is non-zero.
- `grant_idx`, output, `$clog2(N)`: binary index of the current holder. Holds the last holder while idle.

## Operation

Internal state:
- `h`: index of the current or last holder.
- `cnt` (`CW` bits): cycles used in the current burst.
- `lim` (`CW` bits): burst limit, latched from `weights[h]` at grant start (0 mapped to 1).
- Registered `grant_outputs` and `grant_valid`.

Every rising edge with `rst` high:
- **HOLD**: if `grant_valid`, `req_inputs[h]` is high and `cnt < lim`:
  - keep the grant;
  - `cnt <= cnt + 1`.
- **ARBITRATE**: otherwise, search `req_inputs` cyclically from `h+1` through `h+N` (mod N), so `h` itself is checked last. The first set bit j wins:
  - `grant_outputs <= 1<<j`, `grant_valid <= 1`, `h <= j`, `grant_idx <= j`;
  - `cnt <= 1`, `lim <= max(weights[j], 1)`.
- **IDLE**: if no requests are present:
  - `grant_outputs <= 0`, `grant_valid <= 0`;
  - `h` and `grant_idx` are unchanged, so fairness resumes after the last holder.

Boundary rules:
- A sole requester is re-granted a fresh burst on expiry. `grant_outputs` stays at the same one-hot value; `cnt` restarts at 1.
- A holder that drops its request mid-burst loses the grant at the next edge, and arbitration runs in that same edge. An unused remainder of the burst is not banked.
- Weight changes do not affect a burst in progress; they are applied at the next grant start.
- Requests arriving mid-burst from other requesters wait until the burst expires or the holder drops its request.
- Worst-case wait for a continuously requesting input is the sum of the other requesters' limits, in cycles.
- `cnt` never exceeds `lim`, and `lim` is at most `2^CW-1`, so there is no wrap-around.

## Timing

- Reset (`rst` low at an edge): `grant_outputs=0`, `grant_valid=0`, `grant_idx=0`, `cnt=0`, `lim=1`.
  - `h=N-1`, so the first search starts at requester 0.
  - Reset overrides any request in the same edge.
  - Reset mid-burst aborts the burst.
- Latency: a request sampled at edge t is reflected in `grant_outputs` after edge t (1 cycle), provided arbitration occurs at t.
- Handover: from one holder to the next takes zero idle cycles; there is no bubble between bursts.
- Outputs are purely registered. There is no combinational path from `req_inputs` to any output.

## Test plan

All scenarios use N=4, CW=4.

1. **Reset**: hold `rst=0` for 2 edges with `req_inputs=4'b1111` → `grant_outputs=0000`, `grant_valid=0`, `grant_idx=0`. After release, the first grant is `0001`.
2. **Sole requester**: `req_inputs=0001`, all weights 1 → `grant_outputs=0001` on every cycle from the first edge, `grant_valid=1` continuously.
3. **Equal weights**: `req_inputs=1111`, all weights 1 → grants `0001, 0010, 0100, 1000, 0001` on consecutive cycles.
4. **Weighted**: `weights={w3=0, w2=2, w1=1, w0=3}`, `req_inputs=1111` → `0001` for 3 cycles, `0010` for 1, `0100` for 2, `1000` for 1, then repeat.
5. **Drop mid-burst and idle resume**: weights w0=3, others 1, `req_inputs=0101`. Requester 0 drops its request after its first granted cycle → `0100` is granted on the next edge. Then set `req_inputs=0000` → `grant_valid=0`, `grant_idx=2`. Then `req_inputs=0101` → `0001` is granted next, because the search starts after index 2.
6. **Reset mid-burst and weight change**:
   - w0=5, `req_inputs=1111`; assert `rst=0` on the 3rd cycle of the burst → outputs are zero after that edge, and the next grant is `0001` with a fresh 5-cycle burst.
   - Change w0 to 1 during that fresh burst → the current burst still lasts 5 cycles; the next burst for requester 0 lasts 1 cycle.
